// File: rtl/envelope_ctrl_pkg.sv
// Shared definitions for the tone-channel envelope sequencer: state encodings,
// rate field width and the per-state rate selector.
package envelope_ctrl_pkg;

  localparam int RATE_W = 4;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ATTACK  = 3'd1;
  localparam logic [2:0] ST_DECAY   = 3'd2;
  localparam logic [2:0] ST_SUSTAIN = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  function automatic logic [RATE_W-1:0] sel_rate(
    input logic [2:0]        state,
    input logic [RATE_W-1:0] attack_rate,
    input logic [RATE_W-1:0] decay_rate,
    input logic [RATE_W-1:0] release_rate
  );
    case (state)
      ST_ATTACK:  return attack_rate;
      ST_DECAY:   return decay_rate;
      ST_RELEASE: return release_rate;
      default:    return '0;
    endcase
  endfunction

endpackage

// File: rtl/envelope_ctrl_prescaler.sv
// Tick prescaler: counts sample ticks and emits a one-cycle step pulse every
// (rate+1) << PRESCALE_SHIFT ticks; clear restarts the period.
module env_prescaler
  import envelope_ctrl_pkg::*;
#(
  parameter int PRESCALE_SHIFT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              clear,
  input  logic [RATE_W-1:0] rate,
  output logic              step
);

  localparam int CNT_W = RATE_W + PRESCALE_SHIFT;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] limit;

  // (rate+1) << shift, minus one, without a wider intermediate
  assign limit = (CNT_W'(rate) << PRESCALE_SHIFT) | CNT_W'((1 << PRESCALE_SHIFT) - 1);

  // >= so a live rate decrease below the running count still terminates the period
  assign step = tick & (cnt >= limit);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= step ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/envelope_ctrl.sv
// ADSR envelope sequencer for tone channel A: gate edge detect, state machine,
// saturating envelope register and registered mixer-facing outputs.
module envelope_ctrl
  import envelope_ctrl_pkg::*;
#(
  parameter int PRESCALE_SHIFT = 4,
  parameter int ENV_W          = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              gate,
  input  logic [RATE_W-1:0] attack_rate,
  input  logic [RATE_W-1:0] decay_rate,
  input  logic [ENV_W-1:0]  sustain_level,
  input  logic [RATE_W-1:0] release_rate,
  output logic [ENV_W-1:0]  env_out,
  output logic              active,
  output logic [2:0]        state_out
);

  localparam logic [ENV_W-1:0] ENV_MAX = '1;

  logic [2:0]        state, state_nxt;
  logic [ENV_W-1:0]  env, env_nxt, env_stepped;
  logic              gate_q, rise, fall;
  logic              step, state_chg;
  logic [RATE_W-1:0] rate;

  assign rise      = gate & ~gate_q;
  assign fall      = ~gate & gate_q;
  assign rate      = sel_rate(state, attack_rate, decay_rate, release_rate);
  assign state_chg = (state_nxt != state);

  env_prescaler #(
    .PRESCALE_SHIFT (PRESCALE_SHIFT)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .clear (state_chg),
    .rate  (rate),
    .step  (step)
  );

  always_comb begin
    env_stepped = env;
    if (step) begin
      case (state)
        ST_ATTACK:            if (env != ENV_MAX) env_stepped = env + ENV_W'(1);
        ST_DECAY, ST_RELEASE: if (env != '0)      env_stepped = env - ENV_W'(1);
        default:              env_stepped = env;
      endcase
    end
  end

  // Edge-driven transitions hold the level; otherwise exits test the post-step value
  always_comb begin
    state_nxt = state;
    env_nxt   = env_stepped;
    if (rise) begin
      state_nxt = ST_ATTACK;
      env_nxt   = env;
    end else if (fall && (state == ST_ATTACK || state == ST_DECAY || state == ST_SUSTAIN)) begin
      state_nxt = ST_RELEASE;
      env_nxt   = env;
    end else begin
      case (state)
        ST_ATTACK:  if (env_stepped == ENV_MAX)      state_nxt = ST_DECAY;
        ST_DECAY:   if (env_stepped <= sustain_level) state_nxt = ST_SUSTAIN;
        ST_RELEASE: if (env_stepped == '0)           state_nxt = ST_IDLE;
        default:    state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      env    <= '0;
      active <= 1'b0;
      gate_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      env    <= env_nxt;
      active <= (state_nxt != ST_IDLE);
      gate_q <= gate;
    end
  end

  assign env_out   = env;
  assign state_out = state;

endmodule

// File: tb/tb_envelope_ctrl.sv
// Directed bench for envelope_ctrl with PRESCALE_SHIFT=0 and hand-computed
// envelope trajectories.
module tb_envelope_ctrl;
  import envelope_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst, tick, gate;
  logic [3:0] attack_rate, decay_rate, sustain_level, release_rate;
  logic [3:0] env_out;
  logic       active;
  logic [2:0] state_out;

  int checks     = 0;
  int failures   = 0;
  int tick_every = 1;
  int tick_phase = 0;

  always #5 clk = ~clk;

  envelope_ctrl #(
    .PRESCALE_SHIFT (0),
    .ENV_W          (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .tick          (tick),
    .gate          (gate),
    .attack_rate   (attack_rate),
    .decay_rate    (decay_rate),
    .sustain_level (sustain_level),
    .release_rate  (release_rate),
    .env_out       (env_out),
    .active        (active),
    .state_out     (state_out)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic expect_st(input string tag, input int st, input int env, input int act);
    check({tag, ".state"},  int'(state_out), st);
    check({tag, ".env"},    int'(env_out),   env);
    check({tag, ".active"}, int'(active),    act);
  endtask

  // Drives tick for each cycle, then samples 1 time unit after the rising edge
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick = (tick_every <= 1) || ((tick_phase % tick_every) == tick_every - 1);
      tick_phase++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; gate = 1'b0; tick = 1'b1;
    attack_rate = 4'd0; decay_rate = 4'd1; sustain_level = 4'd8; release_rate = 4'd0;

    // Reset
    run(2);
    expect_st("reset", 0, 0, 0);
    rst = 1'b0;
    run(1);
    expect_st("idle", 0, 0, 0);

    // Attack at rate 0: one step per tick
    gate = 1'b1;
    run(1);
    expect_st("atk_enter", 1, 0, 1);
    run(14);
    expect_st("atk_14", 1, 14, 1);
    run(1);
    expect_st("atk_to_decay", 2, 15, 1);

    // Decay at rate 1 to sustain 8
    run(13);
    expect_st("decay_9", 2, 9, 1);
    run(1);
    expect_st("decay_to_sus", 3, 8, 1);
    run(5);
    expect_st("sus_hold", 3, 8, 1);
    sustain_level = 4'd12;
    run(3);
    expect_st("sus_raise", 3, 8, 1);
    sustain_level = 4'd8;

    // Release at rate 0 to idle
    gate = 1'b0;
    run(1);
    expect_st("rel_enter", 4, 8, 1);
    run(7);
    expect_st("rel_1", 4, 1, 1);
    run(1);
    expect_st("rel_to_idle", 0, 0, 0);
    run(2);
    expect_st("idle_hold", 0, 0, 0);

    // Fall in attack, then retrigger from release at 5
    gate = 1'b1;
    run(8);
    expect_st("atk_7", 1, 7, 1);
    gate = 1'b0;
    run(1);
    expect_st("atk_fall", 4, 7, 1);
    run(2);
    expect_st("rel_5", 4, 5, 1);
    gate = 1'b1;
    run(1);
    expect_st("retrig", 1, 5, 1);
    run(9);
    expect_st("retrig_14", 1, 14, 1);
    run(1);
    expect_st("retrig_decay", 2, 15, 1);

    // Sustain level at max leaves decay immediately
    sustain_level = 4'd15;
    run(1);
    expect_st("sus_max", 3, 15, 1);
    gate = 1'b0;
    run(1);
    expect_st("rel_15", 4, 15, 1);
    run(15);
    expect_st("rel_full", 0, 0, 0);

    // Tick every 4th cycle, attack rate 2: one step per 12 cycles
    sustain_level = 4'd8;
    attack_rate   = 4'd2;
    tick_every    = 4;
    tick_phase    = 0;
    gate = 1'b1;
    run(1);
    expect_st("slow_enter", 1, 0, 1);
    run(10);
    expect_st("slow_pre", 1, 0, 1);
    run(1);
    expect_st("slow_step1", 1, 1, 1);
    run(12);
    expect_st("slow_step2", 1, 2, 1);

    // Reset mid-attack with gate held high
    rst = 1'b1;
    run(1);
    expect_st("mid_rst", 0, 0, 0);
    rst = 1'b0;
    run(1);
    expect_st("post_rst", 1, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
